// File: rtl/piso_tx_if.sv
// Parallel-in handshake and serial-out stream bundle for piso_tx.
// master drives words in and watches the stream; slave is the serializer.
interface piso_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sdo;
    logic             sdo_valid;
    logic             frame_start;
    logic             frame_end;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  sdo,
        input  sdo_valid,
        input  frame_start,
        input  frame_end
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output sdo,
        output sdo_valid,
        output frame_start,
        output frame_end
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: MSB-first frames with framing strobes.
// Define PISO_TX_PARITY_EN to append an even-parity bit after bit 0 of every frame.
module piso_tx #(
    parameter int unsigned WIDTH = 8
) (
    input logic     clk,
    input logic     rst_n,
    piso_tx_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
`ifdef PISO_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic last_bit;
    logic ready;
    logic xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shreg_q  <= '0;
`ifdef PISO_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
`ifdef PISO_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Outputs describe the bit currently held by the registers, so they are
    // all decoded from flops; in_ready depends on state only.
    always_comb begin
`ifdef PISO_TX_PARITY_EN
        last_bit = (state_q == StParity);
        bus.sdo  = ((state_q == StShift) && shreg_q[WIDTH-1]) ||
                   ((state_q == StParity) && parity_q);
`else
        last_bit = (state_q == StShift) && (cnt_q == '0);
        bus.sdo  = (state_q == StShift) && shreg_q[WIDTH-1];
`endif
        ready           = (state_q == StIdle) || last_bit;
        xfer            = bus.in_valid && ready;
        bus.in_ready    = ready;
        bus.sdo_valid   = (state_q != StIdle);
        bus.frame_start = (state_q == StShift) && (cnt_q == CntMax);
        bus.frame_end   = last_bit;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
`ifdef PISO_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StShift: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - 1'b1;
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
`ifdef PISO_TX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            StParity: begin
                state_d = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // A load in the final-bit cycle overrides the return to idle.
        if (xfer) begin
            state_d  = StShift;
            cnt_d    = CntMax;
            shreg_d  = bus.in_data;
`ifdef PISO_TX_PARITY_EN
            parity_d = ^bus.in_data;
`endif
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: queue-based frame model plus directed and random stimulus.
// Covers the optional parity build when PISO_TX_PARITY_EN is defined.
module tb_piso_tx;
    localparam int unsigned W  = 8;
    localparam int unsigned W5 = 5;
`ifdef PISO_TX_PARITY_EN
    localparam int unsigned Par = 1;
`else
    localparam int unsigned Par = 0;
`endif
    localparam int unsigned Frame  = W + Par;
    localparam int unsigned Frame5 = W5 + Par;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(W))  bus ();
    piso_tx_if #(.WIDTH(W5)) bus5 ();

    piso_tx #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    piso_tx #(.WIDTH(W5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic b;
        logic s;
        logic e;
    } ent_t;
    ent_t exp_q[$];

    // Vector layout: {sdo, sdo_valid, frame_start, frame_end, in_ready}
    logic [4:0] o_vec;
    logic [4:0] e_vec;

    function automatic logic [4:0] sample_vec();
        return {bus.sdo, bus.sdo_valid, bus.frame_start, bus.frame_end, bus.in_ready};
    endfunction

    // Expected frame: MSB first, then the even-parity bit when enabled.
    task automatic push_frame(input logic [W-1:0] d);
        ent_t en;
        for (int i = W - 1; i >= 0; i--) begin
            en.b = d[i];
            en.s = (i == W - 1);
            en.e = (i == 0) && (Par == 0);
            exp_q.push_back(en);
        end
        if (Par != 0) begin
            en.b = ^d;
            en.s = 1'b0;
            en.e = 1'b1;
            exp_q.push_back(en);
        end
    endtask

    // One cycle: apply inputs after the edge, sample mid-cycle, advance the model.
    task automatic drive(input logic v, input logic [W-1:0] d);
        logic rdy;
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_data  = d;
        @(negedge clk);
        o_vec = sample_vec();
        rdy   = (exp_q.size() <= 1);
        if (exp_q.size() > 0) begin
            e_vec = {exp_q[0].b, 1'b1, exp_q[0].s, exp_q[0].e, rdy};
            void'(exp_q.pop_front());
        end else begin
            e_vec = {4'b0000, rdy};
        end
        if (v && rdy) push_frame(d);
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus5.in_valid = 1'b0;
        bus5.in_data  = '0;
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (sample_vec() !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset.outputs got %b want 00001", sample_vec());
        end
        n_checks++;
        if ({bus5.sdo_valid, bus5.in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset.w5 {valid,ready} got %b want 01",
                     {bus5.sdo_valid, bus5.in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, W'($urandom));
            n_checks++;
            if (o_vec !== e_vec) begin
                n_fail++;
                $display("FAIL reset.idle cyc %0d got %b want %b", c, o_vec, e_vec);
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] got = '0;
        for (int c = 0; c <= int'(Frame) + 2; c++) begin
            if (c == 0) drive(1'b1, 8'hA5);
            else        drive(1'b0, W'($urandom));
            n_checks++;
            if (o_vec !== e_vec) begin
                n_fail++;
                $display("FAIL single cyc %0d got %b want %b", c, o_vec, e_vec);
            end
            if (c >= 1 && c <= int'(W)) got[W-c] = o_vec[4];
            if (c == 1) begin
                n_checks++;
                if (o_vec[2] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single.frame_start got %b want 1", o_vec[2]);
                end
            end
            if (c == int'(Frame)) begin
                n_checks++;
                if (o_vec[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single.frame_end got %b want 1", o_vec[1]);
                end
            end
        end
        n_checks++;
        if (got !== 8'hA5) begin
            n_fail++;
            $display("FAIL single.stream got %h want a5", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdy_m = '0;
        logic [31:0] vld_m = '0;
        logic [31:0] st_m  = '0;
        logic [31:0] want;
        for (int c = 0; c <= 3 * int'(Frame); c++) begin
            if (c == 0)                drive(1'b1, 8'hFF);
            else if (c <= int'(Frame)) drive(1'b1, 8'h00);
            else                       drive(1'b0, 8'h00);
            n_checks++;
            if (o_vec !== e_vec) begin
                n_fail++;
                $display("FAIL b2b cyc %0d got %b want %b", c, o_vec, e_vec);
            end
            if (c < 32) begin
                rdy_m[c] = o_vec[0];
                vld_m[c] = o_vec[3];
                st_m[c]  = o_vec[2];
            end
        end
        want = 32'h1 | (32'h1 << Frame) | (32'h1 << (2 * Frame));
        n_checks++;
        if (rdy_m[2*Frame:0] !== want[2*Frame:0]) begin
            n_fail++;
            $display("FAIL b2b.ready_cycles got %b want %b", rdy_m[2*Frame:0], want[2*Frame:0]);
        end
        want = ((32'h1 << (2 * Frame)) - 1) << 1;
        n_checks++;
        if (vld_m[2*Frame+1:0] !== want[2*Frame+1:0]) begin
            n_fail++;
            $display("FAIL b2b.valid_cycles got %b want %b", vld_m[2*Frame+1:0],
                     want[2*Frame+1:0]);
        end
        want = (32'h1 << 1) | (32'h1 << (Frame + 1));
        n_checks++;
        if (st_m[2*Frame+1:0] !== want[2*Frame+1:0]) begin
            n_fail++;
            $display("FAIL b2b.start_cycles got %b want %b", st_m[2*Frame+1:0],
                     want[2*Frame+1:0]);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] got = '0;
        for (int c = 0; c <= int'(Frame) + 1; c++) begin
            if (c == 0)               drive(1'b1, 8'h3C);
            else if (c < int'(Frame)) drive(1'b1, c[0] ? 8'hC3 : 8'h3C);
            else                      drive(1'b0, 8'hC3);
            n_checks++;
            if (o_vec !== e_vec) begin
                n_fail++;
                $display("FAIL backpressure cyc %0d got %b want %b", c, o_vec, e_vec);
            end
            if (c >= 1 && c <= int'(W)) got[W-c] = o_vec[4];
        end
        n_checks++;
        if (got !== 8'h3C) begin
            n_fail++;
            $display("FAIL backpressure.stream got %h want 3c", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 8'hA5);
            n_checks++;
            if (o_vec !== e_vec) begin
                n_fail++;
                $display("FAIL rstmid.pre cyc %0d got %b want %b", c, o_vec, e_vec);
            end
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sample_vec() !== 5'b00001) begin
            n_fail++;
            $display("FAIL rstmid.immediate got %b want 00001", sample_vec());
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        w = W'($urandom);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid.ready_after_release got %b want 1", bus.in_ready);
        end
        push_frame(w);
        for (int c = 1; c <= int'(Frame) + 2; c++) begin
            drive(1'b0, W'($urandom));
            n_checks++;
            if (o_vec !== e_vec) begin
                n_fail++;
                $display("FAIL rstmid.post cyc %0d got %b want %b", c, o_vec, e_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300 + int'(Frame) + 2; c++) begin
            drive((c < 300) && ($urandom_range(0, 3) != 0), W'($urandom));
            n_checks++;
            if (o_vec !== e_vec) begin
                n_fail++;
                $display("FAIL random cyc %0d got %b want %b", c, o_vec, e_vec);
            end
        end
    endtask

`ifdef PISO_TX_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] words [2] = '{8'h07, 8'h03};
        logic         pbits [2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c <= int'(Frame) + 1; c++) begin
                drive(c == 0, words[k]);
                n_checks++;
                if (o_vec !== e_vec) begin
                    n_fail++;
                    $display("FAIL parity w%0d cyc %0d got %b want %b", k, c, o_vec, e_vec);
                end
                if (c == int'(Frame)) begin
                    n_checks++;
                    if ({o_vec[4], o_vec[3], o_vec[1]} !== {pbits[k], 2'b11}) begin
                        n_fail++;
                        $display("FAIL parity.bit w%0d {sdo,valid,end} got %b want %b", k,
                                 {o_vec[4], o_vec[3], o_vec[1]}, {pbits[k], 2'b11});
                    end
                end
            end
        end
    endtask
`endif

    task automatic test_odd_width();
        logic [5:0] got  = '0;
        logic [5:0] want = (Par != 0) ? 6'b100111 : 6'b010011;
        int         nbits = 0;
        @(posedge clk);
        #1;
        bus5.in_valid = 1'b1;
        bus5.in_data  = 5'b10011;
        @(negedge clk);
        n_checks++;
        if (bus5.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL odd.ready_idle got %b want 1", bus5.in_ready);
        end
        for (int c = 1; c <= int'(Frame5) + 2; c++) begin
            @(posedge clk);
            #1;
            bus5.in_valid = 1'b0;
            bus5.in_data  = W5'($urandom);
            @(negedge clk);
            if (bus5.sdo_valid === 1'b1) begin
                got = {got[4:0], bus5.sdo};
                nbits++;
            end
            if (c == 1 || c == int'(Frame5)) begin
                n_checks++;
                if ({bus5.frame_start, bus5.frame_end} !==
                    {c == 1, c == int'(Frame5)}) begin
                    n_fail++;
                    $display("FAIL odd.strobes cyc %0d got %b", c,
                             {bus5.frame_start, bus5.frame_end});
                end
            end
        end
        n_checks++;
        if (nbits != int'(Frame5)) begin
            n_fail++;
            $display("FAIL odd.bit_count got %0d want %0d", nbits, Frame5);
        end
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL odd.stream got %b want %b", got, want);
        end
        n_checks++;
        if ({bus5.sdo_valid, bus5.in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL odd.idle {valid,ready} got %b want 01",
                     {bus5.sdo_valid, bus5.in_ready});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef PISO_TX_PARITY_EN
        test_parity();
`endif
        test_odd_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, giving the parallel word width in bits, with WIDTH >= 2.
REQ-002 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL provide port in_data, input, WIDTH bits: the parallel word to serialize.
REQ-005 The block SHALL provide port in_valid, input, 1 bit: in_data holds a word to transfer.
REQ-006 The block SHALL provide port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 The block SHALL provide port sdo, output, 1 bit: registered serial data, one bit per cycle.
REQ-008 The block SHALL provide port sdo_valid, output, 1 bit: sdo carries a frame bit this cycle.
REQ-009 The block SHALL provide port frame_start, output, 1 bit: sdo carries the first bit of a frame.
REQ-010 The block SHALL provide port frame_end, output, 1 bit: sdo carries the last bit of a frame.

Function
REQ-011 A transfer SHALL occur on a rising clk edge where in_valid and in_ready are both 1; in_data is captured into an internal shift register on that edge.
REQ-012 The FSM SHALL have states IDLE, SHIFT, and, with the parity feature only, PARITY.
REQ-013 IDLE -> SHIFT SHALL occur on a transfer; with no transfer, the FSM SHALL stay in IDLE.
REQ-014 SHIFT SHALL emit WIDTH bits MSB first, one per cycle, using a bit counter of $clog2(WIDTH) bits that runs from WIDTH-1 down to 0.
REQ-015 Latency: the first bit (in_data[WIDTH-1]) SHALL appear on sdo in the cycle after the transfer edge, with sdo_valid=1 and frame_start=1.
REQ-016 sdo_valid SHALL be 1 for exactly every frame-bit cycle; in IDLE, sdo_valid, frame_start and frame_end SHALL be 0 and sdo SHALL be 0.
REQ-017 frame_end SHALL be 1 only in the cycle carrying the frame's final bit: bit 0 without parity, the parity bit with parity.
REQ-018 in_ready SHALL be combinational from state only: 1 in IDLE and in the final-bit cycle of a frame, 0 otherwise; it SHALL NOT depend on in_valid.
REQ-019 Back-to-back: a transfer in a final-bit cycle SHALL start the next frame in the immediately following cycle, with frame_start=1 and no idle gap.
REQ-020 If there is no transfer in the final-bit cycle, the FSM SHALL return to IDLE.
REQ-021 in_data and in_valid changes while in_ready=0 SHALL be ignored; the frame in flight SHALL NOT be corrupted.
REQ-022 When WIDTH is not a power of two, the counter SHALL still terminate at 0 with no extra bits emitted.

Reset
REQ-023 While rst_n=0, the block SHALL immediately set the state to IDLE, clear the shift register and counter, and drive sdo=0, sdo_valid=0, frame_start=0, frame_end=0 and in_ready=1 once released.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; no remaining bits SHALL be emitted after release.
REQ-025 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 The parity feature SHALL be compiled in when the macro PISO_TX_PARITY_EN is defined.
REQ-027 With PISO_TX_PARITY_EN defined, an even-parity bit (XOR of the captured word) SHALL follow bit 0 in state PARITY, making frames WIDTH+1 cycles long.
REQ-028 Without PISO_TX_PARITY_EN, PARITY state, parity logic and the parity bit SHALL NOT exist, and frames SHALL be WIDTH cycles long.

Verification
REQ-029 Single word: WIDTH=8, in_data=8'hA5 transferred at cycle 0 -> sdo = 1,0,1,0,0,1,0,1 in cycles 1-8; frame_start in cycle 1; frame_end in cycle 8; then IDLE with sdo_valid=0.
REQ-030 Back-to-back: 8'hFF then 8'h00 with in_valid held high -> 16 contiguous valid cycles; in_ready=1 only in cycle 0 and cycle 8; frame_start in cycles 1 and 9.
REQ-031 Backpressure: in_data toggles between 8'h3C and 8'hC3 every cycle while in_ready=0 -> the serial stream still equals the originally captured word.
REQ-032 Reset mid-frame: 8'hA5 loaded, rst_n pulled low in cycle 4 -> sdo, sdo_valid, frame_start and frame_end go to 0 immediately; no further bits after release; in_ready=1.
REQ-033 Parity (PISO_TX_PARITY_EN defined): 8'h07 -> 9-bit frame ending with parity bit 1 and frame_end in cycle 9; 8'h03 -> parity bit 0.
REQ-034 Odd width: WIDTH=5, in_data=5'b10011 -> exactly 5 bits 1,0,0,1,1, then IDLE.
